keccak_pad_feeder: RTL and testbench

//   Upstream feeder for the keccak core. It takes a message as 64-bit words

---
 rtl/keccak_pad_feeder.sv | 191 +++++++++++++++++++
 tb/tb_keccak_pad_feeder.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keccak_pad_feeder.sv
// keccak_pad_feeder
//
// Feeds a Keccak core. Message words arrive from a source and receive
// pad10*1 byte padding. The padded stream is cut into RATE_WORDS-word rate
// blocks and driven into the core's din/din_valid input. After the last padded
// word has been taken, last_block pulses for one cycle. Only one message is in
// flight at a time.
//
// Handshakes:
//   source side: a word transfers on a clock edge where in_valid && in_ready.
//                in_ready is combinational and is high only while the FSM can
//                accept message data and the output register is free to load.
//   core side  : a word transfers on a clock edge where din_valid &&
//                !buffer_full. din/din_valid are registered and hold stable
//                while buffer_full && din_valid.
//
// Ports:
//   clock, reset      single clock; asynchronous active-high reset
//   in_data/in_bytes  message word (byte k at [8k+7:8k]) and its valid byte count
//   in_valid/in_last  source word valid / final word of the message
//   in_ready          source word accepted when in_valid && in_ready
//   buffer_full       core refuses din while high
//   ready             core idle, may start a new message
//   din/din_valid     registered word stream to the core
//   last_block        one-cycle pulse after the final padded word has transferred
//   busy              message in progress (any state other than IDLE)
//   dbg_state         current FSM state, for observation only

module keccak_pad_feeder #(
  parameter int RATE_WORDS = 17,
  parameter int WORD_W     = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [WORD_W-1:0] in_data,
  input  logic [3:0]        in_bytes,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  input  logic              buffer_full,
  input  logic              ready,
  output logic [WORD_W-1:0] din,
  output logic              din_valid,
  output logic              last_block,
  output logic              busy,
  output logic [2:0]        dbg_state
);

  localparam int NB     = WORD_W / 8;
  localparam int WIDX_W = (RATE_WORDS > 1) ? $clog2(RATE_WORDS) : 1;
  localparam logic [WIDX_W-1:0] WIDX_LAST = WIDX_W'(RATE_WORDS - 1);
  // Closing pad bit: 0x80 in the most significant byte of the final rate word.
  localparam logic [WORD_W-1:0] END_MARK = {8'h80, {(WORD_W-8){1'b0}}};
  localparam logic [WORD_W-1:0] ONE_WORD = WORD_W'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ABSORB = 3'd1,
    S_PAD1   = 3'd2,
    S_PAD    = 3'd3,
    S_LAST   = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [WORD_W-1:0]   din_q, din_d;
  logic                din_valid_q, din_valid_d;
  logic                last_block_q, last_block_d;
  logic [WIDX_W-1:0]   widx_q, widx_d;

  logic                adv;
  logic                end_slot;
  logic                short_last;
  logic [WORD_W-1:0]   pad_word;
  logic                load;
  logic [WORD_W-1:0]   load_word;

  // Shared datapath helpers.
  always_comb begin
    // The output register may take a new word when it is empty or its
    // current word is being taken by the core this cycle.
    adv      = !din_valid_q || !buffer_full;
    end_slot = (widx_q == WIDX_LAST);
    // Only a final word with fewer than NB bytes gets in-word padding; any
    // other byte count (including out-of-range values) is treated as full.
    short_last = in_last && (in_bytes < 4'(NB));
    pad_word = '0;
    for (int k = 0; k < NB; k++) begin
      if (4'(k) < in_bytes) begin
        pad_word[8*k +: 8] = in_data[8*k +: 8];
      end else if (4'(k) == in_bytes) begin
        pad_word[8*k +: 8] = 8'h01;
      end
    end
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      din_q        <= '0;
      din_valid_q  <= 1'b0;
      last_block_q <= 1'b0;
      widx_q       <= '0;
    end else begin
      state_q      <= state_d;
      din_q        <= din_d;
      din_valid_q  <= din_valid_d;
      last_block_q <= last_block_d;
      widx_q       <= widx_d;
    end
  end

  // Next-state and output-register load logic.
  always_comb begin
    state_d      = state_q;
    din_d        = din_q;
    din_valid_d  = din_valid_q;
    last_block_d = 1'b0;
    widx_d       = widx_q;
    load         = 1'b0;
    load_word    = '0;

    case (state_q)
      S_IDLE, S_ABSORB: begin
        if (adv && in_valid) begin
          load = 1'b1;
          if (short_last) begin
            load_word = pad_word | (end_slot ? END_MARK : '0);
            state_d   = end_slot ? S_LAST : S_PAD;
          end else begin
            load_word = in_data;
            state_d   = in_last ? S_PAD1 : S_ABSORB;
          end
        end
      end
      S_PAD1: begin
        // Message ended on a full word: the 0x01 pad byte needs its own word.
        if (adv) begin
          load      = 1'b1;
          load_word = ONE_WORD | (end_slot ? END_MARK : '0);
          state_d   = end_slot ? S_LAST : S_PAD;
        end
      end
      S_PAD: begin
        if (adv) begin
          load      = 1'b1;
          load_word = end_slot ? END_MARK : '0;
          if (end_slot) begin
            state_d = S_LAST;
          end
        end
      end
      S_LAST: begin
        // Once the final word has left the register, raise the pulse; it
        // appears on the next cycle, never alongside din_valid.
        if (!din_valid_q) begin
          last_block_d = 1'b1;
          state_d      = S_DONE;
        end
      end
      S_DONE: begin
        if (ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (adv) begin
      din_valid_d = load;
      if (load) begin
        din_d  = load_word;
        widx_d = end_slot ? '0 : widx_q + WIDX_W'(1);
      end
    end
  end

  // Outputs.
  always_comb begin
    in_ready   = !reset && adv && ((state_q == S_IDLE) || (state_q == S_ABSORB));
    busy       = (state_q != S_IDLE);
    din        = din_q;
    din_valid  = din_valid_q;
    last_block = last_block_q;
    dbg_state  = state_q;
  end

endmodule

// File: tb/tb_keccak_pad_feeder.sv
module tb_keccak_pad_feeder;

  localparam int RW = 17;
  localparam int W  = 64;
  localparam int RB = RW * 8;

  logic         clock;
  logic         reset;
  logic [W-1:0] in_data;
  logic [3:0]   in_bytes;
  logic         in_valid;
  logic         in_last;
  logic         in_ready;
  logic         buffer_full;
  logic         ready;
  logic [W-1:0] din;
  logic         din_valid;
  logic         last_block;
  logic         busy;
  logic [2:0]   dbg_state;

  keccak_pad_feeder #(.RATE_WORDS(RW), .WORD_W(W)) dut (
    .clock       (clock),
    .reset       (reset),
    .in_data     (in_data),
    .in_bytes    (in_bytes),
    .in_valid    (in_valid),
    .in_last     (in_last),
    .in_ready    (in_ready),
    .buffer_full (buffer_full),
    .ready       (ready),
    .din         (din),
    .din_valid   (din_valid),
    .last_block  (last_block),
    .busy        (busy),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  logic [7:0]   msg_b[$];
  int           n_vec = 0;
  int           n_err = 0;
  int           xfer_cnt = 0;
  int           pulse_cnt = 0;
  bit           prev_stall = 0;
  bit           prev_acc = 0;
  bit           prev_last = 0;
  logic [W-1:0] prev_din = '0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: bound expired, event did not occur (t=%0t)", name, $time);
  endtask

  // Model: message bytes, then 0x01, zeros to a whole number of rate blocks,
  // and 0x80 OR'ed into the very last byte. Packed little-endian into words.
  task automatic model_msg(input int nbytes, input bit use_fill, input logic [7:0] fill);
    logic [7:0]   pb[$];
    logic [W-1:0] w;
    msg_b.delete();
    for (int i = 0; i < nbytes; i++) msg_b.push_back(use_fill ? fill : 8'(i * 37 + 5));
    pb = msg_b;
    pb.push_back(8'h01);
    while (pb.size() % RB != 0) pb.push_back(8'h00);
    pb[$] = pb[$] | 8'h80;
    for (int i = 0; i < pb.size(); i += 8) begin
      w = '0;
      for (int k = 0; k < 8; k++) w[8*k +: 8] = pb[i+k];
      exp_q.push_back(w);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_word(input logic [W-1:0] d, input logic [3:0] nb, input bit last);
    int guard;
    in_data  = d;
    in_bytes = nb;
    in_last  = last;
    in_valid = 1'b1;
    guard = 0;
    @(negedge clock);
    while (!in_ready && guard < 500) begin
      guard++;
      @(negedge clock);
    end
    if (!in_ready) timeout_fail("accept_timeout");
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_bytes = 4'd0;
  endtask

  // Unused bytes of a short last word carry 0xEE so masking is exercised.
  task automatic send_msg(input int nbytes);
    int nw;
    nw = (nbytes == 0) ? 1 : (nbytes + 7) / 8;
    for (int j = 0; j < nw; j++) begin
      logic [W-1:0] d;
      int nb;
      d  = {8{8'hEE}};
      nb = (nbytes - 8 * j > 8) ? 8 : nbytes - 8 * j;
      for (int k = 0; k < nb; k++) d[8*k +: 8] = msg_b[8*j + k];
      send_word(d, 4'(nb), j == nw - 1);
    end
  endtask

  task automatic wait_pulse(input int target);
    int guard;
    guard = 0;
    while (pulse_cnt < target && guard < 2000) begin
      guard++;
      @(negedge clock);
    end
    if (pulse_cnt < target) timeout_fail("last_block_timeout");
    @(posedge clock);
    #1;
  endtask

  // ---------------- compare process ----------------
  always @(negedge clock) begin
    if (reset) begin
      prev_stall = 0;
      prev_acc   = 0;
      prev_last  = 0;
    end else begin
      if (prev_stall) begin
        check("stall_din_valid", W'(din_valid), W'(1));
        check("stall_din", din, prev_din);
      end
      if (prev_acc) check("accept_latency", W'(din_valid), W'(1));
      if (din_valid && buffer_full) check("stall_in_ready", W'(in_ready), W'(0));
      if (din_valid && !buffer_full) begin
        xfer_cnt++;
        if (exp_q.size() == 0) check("extra_word", W'(din_valid), W'(0));
        else check("din_word", din, exp_q.pop_front());
      end
      if (last_block) begin
        check("last_no_valid", W'(din_valid), W'(0));
        check("last_words_left", W'(exp_q.size()), W'(0));
        check("last_single_cycle", W'(prev_last), W'(0));
        pulse_cnt++;
      end
      if (in_valid && in_ready)
        assert (in_bytes == 4'd8 || (in_last && in_bytes < 4'd8))
          else $error("bench drove illegal in_bytes %0d", in_bytes);
      prev_stall = din_valid && buffer_full;
      prev_din   = din;
      prev_acc   = in_valid && in_ready;
      prev_last  = last_block;
    end
  end

  // ---------------- directed tests ----------------
  task automatic check_reset_outputs(input string tag);
    check({tag, "_din"}, din, '0);
    check({tag, "_din_valid"}, W'(din_valid), W'(0));
    check({tag, "_last_block"}, W'(last_block), W'(0));
    check({tag, "_in_ready"}, W'(in_ready), W'(0));
    check({tag, "_busy"}, W'(busy), W'(0));
    check({tag, "_state"}, W'(dbg_state), W'(0));
  endtask

  initial begin
    int base;
    int guard;
    reset       = 1'b1;
    in_data     = '0;
    in_bytes    = 4'd0;
    in_valid    = 1'b0;
    in_last     = 1'b0;
    buffer_full = 1'b0;
    ready       = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check_reset_outputs("reset");
    reset = 1'b0;
    @(posedge clock);
    #1;

    // 1: empty message
    model_msg(0, 1'b0, 8'h00);
    check("model_t1_size", W'(exp_q.size()), W'(17));
    check("model_t1_w0", exp_q[0], 64'h0000_0000_0000_0001);
    check("model_t1_w16", exp_q[16], 64'h8000_0000_0000_0000);
    send_msg(0);
    wait_pulse(1);

    // 2: 16 full words + 7-byte last word, all 0xAA
    model_msg(16 * 8 + 7, 1'b1, 8'hAA);
    check("model_t2_size", W'(exp_q.size()), W'(17));
    check("model_t2_w16", exp_q[16], 64'h81AA_AAAA_AAAA_AAAA);
    send_msg(16 * 8 + 7);
    wait_pulse(2);

    // 3: exactly one rate block of message -> extra pad block
    model_msg(RB, 1'b0, 8'h00);
    check("model_t3_size", W'(exp_q.size()), W'(34));
    check("model_t3_w17", exp_q[17], 64'h0000_0000_0000_0001);
    check("model_t3_w33", exp_q[33], 64'h8000_0000_0000_0000);
    send_msg(RB);
    wait_pulse(3);

    // 4: buffer_full held 5 cycles once word 9 is reached
    model_msg(90, 1'b0, 8'h00);
    base = xfer_cnt;
    fork
      send_msg(90);
      begin
        guard = 0;
        while (xfer_cnt < base + 9 && guard < 500) begin
          guard++;
          @(negedge clock);
        end
        if (xfer_cnt < base + 9) timeout_fail("stall_wait");
        @(posedge clock);
        #1;
        buffer_full = 1'b1;
        repeat (5) @(posedge clock);
        #1;
        buffer_full = 1'b0;
      end
    join
    wait_pulse(4);

    // 5: reset while padding at word 5
    model_msg(0, 1'b0, 8'h00);
    base = xfer_cnt;
    send_msg(0);
    guard = 0;
    while (xfer_cnt < base + 5 && guard < 500) begin
      guard++;
      @(negedge clock);
    end
    if (xfer_cnt < base + 5) timeout_fail("reset_wait");
    @(posedge clock);
    #1;
    reset = 1'b1;
    #1;
    check_reset_outputs("midreset");
    exp_q.delete();
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    @(posedge clock);
    #1;
    model_msg(0, 1'b0, 8'h00);
    send_msg(0);
    wait_pulse(5);

    // 6: core not ready after the pulse
    ready = 1'b0;
    model_msg(20, 1'b0, 8'h00);
    send_msg(20);
    wait_pulse(6);
    repeat (20) begin
      @(negedge clock);
      check("done_in_ready", W'(in_ready), W'(0));
      check("done_busy", W'(busy), W'(1));
    end
    @(posedge clock);
    #1;
    ready = 1'b1;
    @(negedge clock);
    check("ready_same_cycle_in_ready", W'(in_ready), W'(0));
    @(negedge clock);
    check("ready_next_cycle_in_ready", W'(in_ready), W'(1));
    @(posedge clock);
    #1;
    model_msg(8, 1'b0, 8'h00);
    send_msg(8);
    wait_pulse(7);
    repeat (2) @(posedge clock);
    #1;
    check("idle_busy", W'(busy), W'(0));
    check("end_queue_empty", W'(exp_q.size()), W'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
